// File: rtl/nx_ram_nar1w_pkg.sv
// Shared types and helpers for the multi-read-port RAM and its init engine.
package nx_ram_pkg;

  // Widest data word the bwe expansion helper can produce.
  localparam int NX_RAM_MAXW = 1024;

  typedef enum logic {
    NX_RAM_IDLE = 1'b0,
    NX_RAM_FILL = 1'b1
  } nx_ram_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int nx_log_vec(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Spread each bwe bit over its WIDTH/BWEWIDTH contiguous data bits; bit 0 = LSB group.
  function automatic logic [NX_RAM_MAXW-1:0] expand_bwe(input logic [NX_RAM_MAXW-1:0] bwe,
                                                        input int width, input int bwewidth);
    logic [NX_RAM_MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < width; i++) m[i] = bwe[i / (width / bwewidth)];
    return m;
  endfunction

endpackage

// File: rtl/nx_ram_nar1w_if.sv
// Read/write/init bus of nx_ram_nar1w; master is the user, slave the RAM.
interface nx_ram_nar1w_if import nx_ram_pkg::*; #(
  parameter int NUM_RD   = 2,
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 256,
  parameter int BWEWIDTH = WIDTH
);
  localparam int AW = nx_log_vec(DEPTH);

  logic                             init;
  logic                             init_done;
  logic [NUM_RD-1:0][AW-1:0]        ra;
  logic [NUM_RD-1:0][WIDTH-1:0]     dout;
  logic                             web;
  logic [AW-1:0]                    wa;
  logic [WIDTH-1:0]                 din;
  logic [BWEWIDTH-1:0]              bwe;
  logic                             wr_drop;

  modport master (output init, ra, web, wa, din, bwe,
                  input  init_done, dout, wr_drop);
  modport slave  (input  init, ra, web, wa, din, bwe,
                  output init_done, dout, wr_drop);
endinterface

// File: rtl/nx_ram_nar1w_init_seq.sv
// Fill engine: walks the array writing INIT_VALUE after reset or an init pulse.
module nx_ram_init_seq import nx_ram_pkg::*; #(
  parameter int               DEPTH         = 256,
  parameter int               WIDTH         = 64,
  parameter int               INIT_ON_RESET = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
  localparam int              AW            = nx_log_vec(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  output logic             init_done,
  output logic             fill_en,
  output logic [AW-1:0]    fill_addr,
  output logic [WIDTH-1:0] fill_data
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  nx_ram_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and fill pointer; reset lands in FILL at word 0 when auto-init is on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? NX_RAM_FILL : NX_RAM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance through the array; an init pulse restarts from word 0 in any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == NX_RAM_FILL) begin
      if (cnt_q == LAST) begin
        state_d = NX_RAM_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (init) begin
      state_d = NX_RAM_FILL;
      cnt_d   = '0;
    end
  end

  assign fill_en   = (state_q == NX_RAM_FILL);
  assign fill_addr = cnt_q;
  assign fill_data = INIT_VALUE;
  assign init_done = (state_q == NX_RAM_IDLE);

endmodule

// File: rtl/nx_ram_nar1w.sv
// NUM_RD async read ports, one bit-group-masked sync write port, hardware init fill.
module nx_ram_nar1w import nx_ram_pkg::*; #(
  parameter int               NUM_RD        = 2,
  parameter int               WIDTH         = 64,
  parameter int               DEPTH         = 256,
  parameter int               BWEWIDTH      = WIDTH,
  parameter int               BYPASS        = 0,
  parameter int               OUT_FLOP      = 0,
  parameter int               INIT_ON_RESET = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
  input logic             clk,
  input logic             rst,
  nx_ram_nar1w_if.slave   bus
);
  localparam int AW = nx_log_vec(DEPTH);

  if (WIDTH % BWEWIDTH != 0) begin : g_chk_bwe
    $error("nx_ram_nar1w: BWEWIDTH must divide WIDTH");
  end
  if (NUM_RD < 1) begin : g_chk_rd
    $error("nx_ram_nar1w: NUM_RD must be at least 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             init_done, fill_en;
  logic [AW-1:0]    fill_addr;
  logic [WIDTH-1:0] fill_data;

  nx_ram_init_seq #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_ON_RESET(INIT_ON_RESET), .INIT_VALUE(INIT_VALUE)
  ) u_init (
    .clk(clk), .rst(rst), .init(bus.init), .init_done(init_done),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data)
  );

  // Write port: read-modify-write merge under the expanded group mask.
  logic             wa_ok, commit, wr_drop_q;
  logic [AW-1:0]    wa_idx;
  logic [WIDTH-1:0] mask, merged;

  assign wa_ok  = 32'(bus.wa) < DEPTH;
  assign wa_idx = wa_ok ? bus.wa : '0;
  assign commit = !bus.web && init_done && wa_ok && !rst;

  // Merge new data into the addressed word under the group mask.
  always_comb begin
    mask   = WIDTH'(expand_bwe(NX_RAM_MAXW'(bus.bwe), WIDTH, BWEWIDTH));
    merged = (mem[wa_idx] & ~mask) | (bus.din & mask);
  end

`ifndef SYNTHESIS
  // Backdoor set: the task posts a request, the array picks it up at the next clock.
  logic             bd_req, bd_ack;
  int               bd_addr;
  logic [WIDTH-1:0] bd_data;
  function automatic logic [WIDTH-1:0] bd_get(input int a);
    return mem[a];
  endfunction
  task automatic bd_set(input int a, input logic [WIDTH-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_req  = !bd_req;
  endtask
`endif

  // Array update: the fill engine owns the port while init_done is low.
  always_ff @(posedge clk) begin
    if (fill_en) mem[fill_addr] <= fill_data;
    else if (commit) mem[wa_idx] <= merged;
`ifndef SYNTHESIS
    bd_ack <= bd_req;
    if (bd_req != bd_ack) mem[bd_addr] <= bd_data;
`endif
  end

  // Flag writes discarded because the array is filling or the address is out of range.
  always_ff @(posedge clk) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= !bus.web && (!init_done || !wa_ok);
  end

  // Read ports, each fully independent.
  logic [NUM_RD-1:0][WIDTH-1:0] rd_c;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic             ra_ok;
    logic [AW-1:0]    ra_idx;
    logic [WIDTH-1:0] rd_v;
    assign ra_ok  = 32'(bus.ra[p]) < DEPTH;
    assign ra_idx = ra_ok ? bus.ra[p] : '0;
    // Priority: fill in progress, out of range, same-cycle bypass, array.
    always_comb begin
      rd_v = mem[ra_idx];
      if (!init_done)                                          rd_v = INIT_VALUE;
      else if (!ra_ok)                                         rd_v = '0;
      else if (BYPASS != 0 && commit && bus.ra[p] == bus.wa)  rd_v = merged;
    end
    assign rd_c[p] = rd_v;
  end

  if (OUT_FLOP != 0) begin : g_oflop
    logic [NUM_RD-1:0][WIDTH-1:0] dout_q;
    // Optional output stage, one cycle behind the combinational read.
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= rd_c;
    end
    assign bus.dout = dout_q;
  end else begin : g_comb
    assign bus.dout = rd_c;
  end

  assign bus.init_done = init_done;
  assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_nx_ram_nar1w.sv
// Scoreboard bench: two RAM flavours (bypass/comb and no-bypass/flopped) share stimulus.
module tb_nx_ram_nar1w;
  localparam int              DEPTH = 200;
  localparam logic [63:0]     INITV = 64'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_ram_nar1w_if #(.NUM_RD(2), .WIDTH(64), .DEPTH(DEPTH), .BWEWIDTH(8)) ifa ();
  nx_ram_nar1w_if #(.NUM_RD(2), .WIDTH(64), .DEPTH(DEPTH), .BWEWIDTH(8)) ifb ();

  nx_ram_nar1w #(.NUM_RD(2), .WIDTH(64), .DEPTH(DEPTH), .BWEWIDTH(8), .BYPASS(1),
                 .OUT_FLOP(0), .INIT_ON_RESET(1), .INIT_VALUE(INITV))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  nx_ram_nar1w #(.NUM_RD(2), .WIDTH(64), .DEPTH(DEPTH), .BWEWIDTH(8), .BYPASS(0),
                 .OUT_FLOP(1), .INIT_ON_RESET(1), .INIT_VALUE(INITV))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic        done;
    logic        drop;
    logic [63:0] a [2];
    logic [63:0] b [2];
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: word array, fill cycles still owed, registered outputs.
  logic [63:0] mem_m [DEPTH];
  int          left = 0;
  logic        drop_m = 1'b0;
  logic [63:0] prevb [2];
  bit          live = 0;

  function automatic logic [63:0] rdval(input int ra, input bit byp, input bit done,
                                        input bit commit, input int wa, input logic [63:0] mg);
    if (!done) return INITV;
    if (ra >= DEPTH) return 64'h0;
    if (byp && commit && ra == wa) return mg;
    return mem_m[ra];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents every output each cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("init_done_a", {63'b0, ifa.init_done}, {63'b0, e.done});
      chk("init_done_b", {63'b0, ifb.init_done}, {63'b0, e.done});
      chk("wr_drop_a", {63'b0, ifa.wr_drop}, {63'b0, e.drop});
      chk("wr_drop_b", {63'b0, ifb.wr_drop}, {63'b0, e.drop});
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("dout_byp_port%0d", p), ifa.dout[p], e.a[p]);
        chk($sformatf("dout_flop_port%0d", p), ifb.dout[p], e.b[p]);
      end
    end
  end

  // One clock of stimulus: drive, push expectation, advance the model, step the clock.
  task automatic cyc(input bit r, input bit ini, input bit we_n, input int wa,
                     input logic [63:0] din, input logic [7:0] bwe, input int ra0, input int ra1);
    exp_t        e;
    bit          done, waok, commit;
    logic [63:0] m, mg, ca [2], cb [2];
    int          ra [2];
    ra[0] = ra0; ra[1] = ra1;
    rst = r;
    ifa.init = ini; ifa.web = we_n; ifa.wa = 8'(wa); ifa.din = din; ifa.bwe = bwe;
    ifb.init = ini; ifb.web = we_n; ifb.wa = 8'(wa); ifb.din = din; ifb.bwe = bwe;
    ifa.ra[0] = 8'(ra0); ifa.ra[1] = 8'(ra1);
    ifb.ra[0] = 8'(ra0); ifb.ra[1] = 8'(ra1);
    done   = (left == 0);
    waok   = (wa < DEPTH);
    commit = !r && !we_n && done && waok;
    m = 64'h0;
    for (int g = 0; g < 8; g++) if (bwe[g]) m[g*8 +: 8] = 8'hFF;
    mg = ((waok ? mem_m[wa] : 64'h0) & ~m) | (din & m);
    for (int p = 0; p < 2; p++) begin
      ca[p] = rdval(ra[p], 1'b1, done, commit, wa, mg);
      cb[p] = rdval(ra[p], 1'b0, done, commit, wa, mg);
    end
    if (live) begin
      e.done = done; e.drop = drop_m;
      e.a = ca; e.b = prevb;
      q.push_back(e);
    end
    // Effects of the coming edge.
    for (int p = 0; p < 2; p++) prevb[p] = r ? 64'h0 : cb[p];
    drop_m = r ? 1'b0 : (!we_n && (!done || !waok));
    if (commit) mem_m[wa] = mg;
    if (left > 0) begin
      mem_m[DEPTH - left] = INITV;
      left--;
    end
    if (r || ini) left = DEPTH;
    if (r) live = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_only(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 1, $urandom_range(0, 215), {$urandom, $urandom}, 8'($urandom),
          $urandom_range(0, 215), $urandom_range(0, 215));
  endtask

  // Random traffic; port 0 often aims at the write address to exercise bypass.
  task automatic rnd(input int n, input int p_init, input int p_rst);
    for (int i = 0; i < n; i++) begin
      int wa, ra0;
      wa  = $urandom_range(0, 215);
      ra0 = ($urandom_range(0, 9) < 3) ? wa : $urandom_range(0, 215);
      cyc(($urandom_range(1, p_rst) == 1), ($urandom_range(1, p_init) == 1),
          $urandom_range(0, 1), wa, {$urandom, $urandom}, 8'($urandom), ra0,
          $urandom_range(0, 215));
    end
  endtask

  initial begin
    cyc(1, 0, 1, 0, 64'h0, 8'h0, 0, 0);
    cyc(1, 0, 1, 0, 64'h0, 8'h0, 0, 0);
    // Write while filling: dropped, word stays at the fill value.
    rd_only(5);
    cyc(0, 0, 0, 3, 64'h1, 8'hFF, 3, 17);
    rd_only(DEPTH);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 0, 17);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 199, 3);
    // Group write enables on a zeroed word.
    cyc(0, 0, 0, 10, 64'h0, 8'hFF, 10, 11);
    cyc(0, 0, 0, 10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 10, 11);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 10, 10);
    // Bypass: port 0 on the written address, port 1 next to it.
    cyc(0, 0, 0, 5, 64'h1234, 8'hFF, 5, 6);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 5, 6);
    // Out-of-range write and read.
    cyc(0, 0, 0, 210, 64'hDEAD, 8'hFF, 210, 199);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 210, 5);
    rnd(600, 1000, 100000);
    // Init pulse, then a restart 100 cycles into the fill.
    cyc(0, 1, 1, 0, 64'h0, 8'h0, 0, 1);
    rd_only(100);
    cyc(0, 1, 0, 4, 64'h77, 8'hFF, 4, 0);
    rd_only(DEPTH + 10);
    // Reset on top of a write: the write must not land.
    cyc(0, 0, 0, 7, 64'h99, 8'hFF, 7, 7);
    cyc(1, 0, 0, 7, 64'h55, 8'hFF, 7, 8);
    rd_only(DEPTH + 2);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 7, 8);
    rnd(1500, 300, 500);
    cyc(0, 0, 1, 0, 64'h0, 8'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
